// File: rtl/peripheral_timer.sv
// Memory-mapped down-counting timer slave: prescaler, 32-bit down counter with
// one-shot/auto-reload modes, W1C expiry status and a level interrupt.
module peripheral_timer #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h8000_0100
) (
    input  logic                  bus_clock,
    input  logic                  bus_reset_n,
    input  logic                  mem_valid_i,
    input  logic                  mem_read_i,
    input  logic                  mem_write_i,
    input  logic [ADDR_WIDTH-1:0] mem_addr_i,
    input  logic [DATA_WIDTH-1:0] mem_data_i,
    output logic                  bus_valid_o,
    output logic [DATA_WIDTH-1:0] bus_data_o,
    output logic                  irq_o
);
    localparam logic [2:0] SEL_CTRL = 3'd0;
    localparam logic [2:0] SEL_PRE  = 3'd1;
    localparam logic [2:0] SEL_LOAD = 3'd2;
    localparam logic [2:0] SEL_CNT  = 3'd3;
    localparam logic [2:0] SEL_STAT = 3'd4;
    localparam logic [DATA_WIDTH-1:0] ONE = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

    logic                  r_en, r_reload, r_irq_en, r_expired;
    logic [DATA_WIDTH-1:0] r_prescale, r_load, r_count, r_pcnt;
    logic [1:0]                 r_vld_pipe;
    logic [1:0][DATA_WIDTH-1:0] r_data_pipe;

    logic                  w_hit, w_wr, w_tick, w_expire;
    logic                  w_wr_ctrl, w_wr_pre, w_wr_load, w_wr_cnt, w_wr_stat;
    logic [2:0]            w_sel;
    logic [DATA_WIDTH-1:0] w_rdata;
    logic                  w_unused;

    assign w_hit     = mem_valid_i && (mem_read_i || mem_write_i) &&
                       (mem_addr_i[ADDR_WIDTH-1:5] == BASE_ADDR[ADDR_WIDTH-1:5]);
    assign w_wr      = w_hit && mem_write_i;
    assign w_sel     = mem_addr_i[4:2];
    assign w_wr_ctrl = w_wr && (w_sel == SEL_CTRL);
    assign w_wr_pre  = w_wr && (w_sel == SEL_PRE);
    assign w_wr_load = w_wr && (w_sel == SEL_LOAD);
    assign w_wr_cnt  = w_wr && (w_sel == SEL_CNT);
    assign w_wr_stat = w_wr && (w_sel == SEL_STAT);
    assign w_unused  = ^mem_addr_i[1:0];

    assign w_tick   = r_en && (r_pcnt == r_prescale);
    assign w_expire = w_tick && (r_count == '0);

    always_comb begin
        w_rdata = '0;
        case (w_sel)
            SEL_CTRL: w_rdata = {{(DATA_WIDTH-3){1'b0}}, r_irq_en, r_reload, r_en};
            SEL_PRE:  w_rdata = r_prescale;
            SEL_LOAD: w_rdata = r_load;
            SEL_CNT:  w_rdata = r_count;
            SEL_STAT: w_rdata = {{(DATA_WIDTH-1){1'b0}}, r_expired};
            default:  w_rdata = '0;
        endcase
    end

    // Two-stage response pipe; stage 0 carries zero data for writes and idle cycles.
    always_ff @(posedge bus_clock or negedge bus_reset_n) begin
        if (!bus_reset_n) begin
            r_vld_pipe  <= '0;
            r_data_pipe <= '0;
        end else begin
            r_vld_pipe     <= {r_vld_pipe[0], w_hit};
            r_data_pipe[0] <= (w_hit && !mem_write_i) ? w_rdata : '0;
            r_data_pipe[1] <= r_data_pipe[0];
        end
    end

    assign bus_valid_o = r_vld_pipe[1];
    assign bus_data_o  = r_data_pipe[1];
    assign irq_o       = r_expired & r_irq_en;

    always_ff @(posedge bus_clock or negedge bus_reset_n) begin
        if (!bus_reset_n) begin
            r_en       <= 1'b0;
            r_reload   <= 1'b0;
            r_irq_en   <= 1'b0;
            r_expired  <= 1'b0;
            r_prescale <= '0;
            r_load     <= '0;
            r_count    <= '0;
            r_pcnt     <= '0;
        end else begin
            if (w_wr_ctrl)
                {r_irq_en, r_reload, r_en} <= mem_data_i[2:0];
            else if (w_expire && !r_reload)
                r_en <= 1'b0;

            if (w_wr_pre)  r_prescale <= mem_data_i;
            if (w_wr_load) r_load     <= mem_data_i;

            if (!r_en || w_tick) r_pcnt <= '0;
            else                 r_pcnt <= r_pcnt + ONE;

            // Bus write to COUNT beats the tick update.
            if (w_wr_cnt)
                r_count <= mem_data_i;
            else if (w_tick && (r_count != '0))
                r_count <= r_count - ONE;
            else if (w_expire && r_reload)
                r_count <= r_load;

            // Expiry set beats a same-cycle W1C.
            if (w_expire)
                r_expired <= 1'b1;
            else if (w_wr_stat && mem_data_i[0])
                r_expired <= 1'b0;
        end
    end
endmodule

// File: tb/tb_peripheral_timer.sv
// Scoreboard bench for peripheral_timer: a register-level model predicts each
// response and the irq level; a monitor checks responses as they appear.
module tb_peripheral_timer;
    localparam logic [31:0] BASE = 32'h8000_0100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mv = 1'b0, mr = 1'b0, mw = 1'b0;
    logic [31:0] ma = '0, md = '0;
    logic        bus_valid_o, irq_o;
    logic [31:0] bus_data_o;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;
    exp_t exp_q[$];

    // Register-level reference state
    logic [2:0]  m_ctrl;
    logic [31:0] m_pre, m_load, m_cnt, m_pcnt;
    logic        m_exp;

    peripheral_timer #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .BASE_ADDR(BASE)) dut (
        .bus_clock(clk), .bus_reset_n(rst_n),
        .mem_valid_i(mv), .mem_read_i(mr), .mem_write_i(mw),
        .mem_addr_i(ma), .mem_data_i(md),
        .bus_valid_o(bus_valid_o), .bus_data_o(bus_data_o), .irq_o(irq_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    function automatic logic [31:0] regval(input logic [2:0] off);
        case (off)
            3'd0: return {29'd0, m_ctrl};
            3'd1: return m_pre;
            3'd2: return m_load;
            3'd3: return m_cnt;
            3'd4: return {31'd0, m_exp};
            default: return 32'd0;
        endcase
    endfunction

    // Model: state as of each edge, with bus writes taking precedence over the timer.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ctrl = 0; m_pre = 0; m_load = 0; m_cnt = 0; m_pcnt = 0; m_exp = 0;
            exp_q.delete();
            cyc = 0;
        end else begin
            logic        hit, tick, expire;
            logic [2:0]  off;
            logic [2:0]  n_ctrl;
            logic [31:0] n_pre, n_load, n_cnt, n_pcnt;
            logic        n_exp;
            cyc++;
            hit = mv && (mr || mw) && (ma[31:5] == BASE[31:5]);
            off = ma[4:2];
            if (hit) exp_q.push_back('{data: (mw ? 32'd0 : regval(off)), due: cyc + 1});

            tick   = m_ctrl[0] && (m_pcnt == m_pre);
            expire = tick && (m_cnt == 0);
            n_ctrl = m_ctrl; n_pre = m_pre; n_load = m_load; n_exp = m_exp;
            n_pcnt = (m_ctrl[0] && !tick) ? m_pcnt + 1 : 32'd0;
            n_cnt  = m_cnt;
            if (tick) n_cnt = (m_cnt != 0) ? m_cnt - 1 : (m_ctrl[1] ? m_load : 32'd0);
            if (expire && !m_ctrl[1]) n_ctrl[0] = 1'b0;
            if (hit && mw && off == 3'd4 && md[0]) n_exp = 1'b0;
            if (expire) n_exp = 1'b1;
            if (hit && mw) begin
                case (off)
                    3'd0: n_ctrl = md[2:0];
                    3'd1: n_pre  = md;
                    3'd2: n_load = md;
                    3'd3: n_cnt  = md;
                    default: ;
                endcase
            end
            m_ctrl = n_ctrl; m_pre = n_pre; m_load = n_load;
            m_cnt = n_cnt; m_pcnt = n_pcnt; m_exp = n_exp;
        end
    end

    // Monitor: pops the scoreboard whenever a response shows up.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus_valid_o) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("rsp_data", bus_data_o, e.data);
                    check("rsp_cycle", cyc, e.due);
                end
            end else begin
                check("idle_data", bus_data_o, 32'd0);
                if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
                    check("missing_valid", 32'd0, 32'd1);
                    void'(exp_q.pop_front());
                end
            end
            check("irq", {31'd0, irq_o}, {31'd0, m_exp & m_ctrl[2]});
        end
    end

    task automatic send(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        mv = 1'b1; mr = r; mw = w; ma = a; md = d;
        @(posedge clk); #1;
        mv = 1'b0; mr = 1'b0; mw = 1'b0;
    endtask

    task automatic wr(input logic [4:0] off, input logic [31:0] d);
        send(1'b0, 1'b1, BASE + {27'd0, off}, d);
    endtask

    task automatic rd(input logic [4:0] off);
        send(1'b1, 1'b0, BASE + {27'd0, off}, 32'd0);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        #2;
        check("rst_valid", {31'd0, bus_valid_o}, 32'd0);
        check("rst_data", bus_data_o, 32'd0);
        check("rst_irq", {31'd0, irq_o}, 32'd0);
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) rd(5'(i * 4));
        idle(3);

        // Basic read/write, unused offset, miss, and read+write treated as write
        wr(5'h08, 32'hDEAD_BEEF);
        rd(5'h08);
        rd(5'h14);
        send(1'b1, 1'b0, 32'h8000_0200, 32'd0);
        wr(5'h18, 32'h1234_5678);
        rd(5'h18);
        send(1'b1, 1'b1, BASE + 32'h4, 32'h0000_0007);
        rd(5'h04);
        send(1'b1, 1'b0, BASE + 32'h7, 32'd0);
        idle(4);

        // One-shot with irq, then W1C
        wr(5'h04, 32'd3);
        wr(5'h0C, 32'd2);
        wr(5'h00, 32'b101);
        idle(13);
        rd(5'h00); rd(5'h0C); rd(5'h10);
        wr(5'h10, 32'd1);
        idle(3);

        // Reset mid-read with irq high
        wr(5'h04, 32'd0);
        wr(5'h0C, 32'd0);
        wr(5'h00, 32'b101);
        idle(2);
        rd(5'h0C);
        rd(5'h00);
        check("pre_rst_valid", {31'd0, bus_valid_o}, 32'd1);
        check("pre_rst_irq", {31'd0, irq_o}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_valid", {31'd0, bus_valid_o}, 32'd0);
        check("midrst_data", bus_data_o, 32'd0);
        check("midrst_irq", {31'd0, irq_o}, 32'd0);
        @(negedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        idle(3);
        for (int i = 0; i < 5; i++) rd(5'(i * 4));
        idle(3);

        // Auto-reload and back-to-back COUNT reads
        wr(5'h04, 32'd0);
        wr(5'h08, 32'd4);
        wr(5'h0C, 32'd0);
        wr(5'h00, 32'b011);
        for (int i = 0; i < 8; i++) rd(5'h0C);
        idle(3);

        // Collisions at varying offsets around tick/expiry
        for (int d = 0; d < 6; d++) begin
            wr(5'h0C, 32'd9);
            idle(d);
            wr(5'h0C, 32'd9);
            rd(5'h0C);
            wr(5'h0C, 32'd0);
            idle(d);
            wr(5'h10, 32'd1);
            rd(5'h10);
        end
        wr(5'h00, 32'd0);
        for (int k = 0; k < 4; k++) begin
            for (int d = k; d < k + 3; d++) begin
                wr(5'h0C, 32'(k));
                wr(5'h00, 32'b101);
                idle(d);
                wr(5'h00, 32'b101);
                rd(5'h00);
                rd(5'h10);
                wr(5'h10, 32'd1);
                wr(5'h00, 32'd0);
            end
        end
        idle(3);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            logic [2:0]  off;
            logic [31:0] a, d;
            int sel;
            off = 3'($urandom_range(0, 7));
            a = BASE + {27'd0, off, 2'($urandom_range(0, 3))};
            if ($urandom_range(0, 15) == 0) a = a ^ (32'd1 << $urandom_range(5, 31));
            case (off)
                3'd1: d = 32'($urandom_range(0, 3));
                3'd2, 3'd3: d = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 6));
                default: d = $urandom;
            endcase
            sel = $urandom_range(0, 9);
            if (sel < 3) idle(1);
            else if (sel < 6) send(1'b1, 1'b0, a, 32'd0);
            else if (sel < 9) send(1'b0, 1'b1, a, d);
            else send(1'b1, 1'b1, a, d);
        end
        idle(5);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
